// File: rtl/qspi_pkg.sv
// Shared QSPI constants and the reader state encoding (also used by the ROM emulator).
// QSPI_CONTINUOUS_READ_EN adds the HOLD state for sequential continuous reads.
package qspi_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DUMMY = 3'd3,
        S_DATA  = 3'd4,
        S_DONE  = 3'd5
`ifdef QSPI_CONTINUOUS_READ_EN
        ,
        S_HOLD  = 3'd6
`endif
    } qspi_state_e;

    localparam logic [7:0] DEFAULT_READ_CMD      = 8'hEB;
    localparam int         DEFAULT_ADDR_BITS     = 24;
    localparam int         DEFAULT_DUMMY_NIBBLES = 4;
    localparam int         CMD_NIBBLES           = 2;
    localparam int         DATA_NIBBLES          = 2;

endpackage

// File: rtl/qspi_rom_reader.sv
// Quad-I/O single-byte reader for a QSPI ROM: command, address, dummy, two data nibbles.
// Define QSPI_CONTINUOUS_READ_EN to keep the chip selected and serve sequential addresses from HOLD.
module qspi_rom_reader
    import qspi_pkg::*;
#(
    parameter int         DUMMY_NIBBLES = DEFAULT_DUMMY_NIBBLES,
    parameter logic [7:0] READ_CMD      = DEFAULT_READ_CMD,
    parameter int         ADDR_BITS     = DEFAULT_ADDR_BITS
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [7:0]           resp_data,
    output logic                 select_n,
    output logic                 sclk,
    output logic [3:0]           io_out,
    output logic                 io_oe,
    input  logic [3:0]           io_in,
    output logic [2:0]           debug_state
);

    localparam logic [7:0] CMD_LAST   = 8'(CMD_NIBBLES - 1);
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS / 4 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIBBLES - 1);
    localparam logic [7:0] DATA_LAST  = 8'(DATA_NIBBLES - 1);

    qspi_state_e          state;
    logic                 phase;
    logic [7:0]           cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] shreg;
    logic [3:0]           rx_hi;
`ifdef QSPI_CONTINUOUS_READ_EN
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
    logic                 restart;
`endif

    assign debug_state = state;

    // Valid/ready: a request is taken on a clock edge where req_valid && req_ready;
    // req_ready is a registered flag that is high only in IDLE (and HOLD), never queued.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state      <= S_IDLE;
            phase      <= 1'b0;
            cnt        <= '0;
            addr_q     <= '0;
            shreg      <= '0;
            rx_hi      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            select_n   <= 1'b1;
            sclk       <= 1'b0;
            io_out     <= '0;
            io_oe      <= 1'b0;
`ifdef QSPI_CONTINUOUS_READ_EN
            restart    <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        select_n  <= 1'b0;
                        state     <= S_CMD;
                        cnt       <= '0;
                        phase     <= 1'b0;
                        io_oe     <= 1'b1;
                        io_out    <= READ_CMD[7:4];
                    end
                end
                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    // Phase 0 holds the nibble with sclk low; phase 1 raises sclk and
                    // its closing edge samples io_in and presents the next nibble.
                    phase <= ~phase;
                    sclk  <= ~phase;
                    if (phase) begin
                        cnt <= cnt + 8'd1;
                        case (state)
                            S_CMD: begin
                                if (cnt == CMD_LAST) begin
                                    state  <= S_ADDR;
                                    cnt    <= '0;
                                    io_out <= addr_q[ADDR_BITS-1 -: 4];
                                    shreg  <= addr_q << 4;
                                end else begin
                                    io_out <= READ_CMD[3:0];
                                end
                            end
                            S_ADDR: begin
                                if (cnt == ADDR_LAST) begin
                                    state  <= S_DUMMY;
                                    cnt    <= '0;
                                    io_oe  <= 1'b0;
                                    io_out <= '0;
                                end else begin
                                    io_out <= shreg[ADDR_BITS-1 -: 4];
                                    shreg  <= shreg << 4;
                                end
                            end
                            S_DUMMY: begin
                                if (cnt == DUMMY_LAST) begin
                                    state <= S_DATA;
                                    cnt   <= '0;
                                end
                            end
                            S_DATA: begin
                                if (cnt != DATA_LAST) begin
                                    rx_hi <= io_in;
                                end else begin
                                    resp_data  <= {rx_hi, io_in};
                                    resp_valid <= 1'b1;
                                    cnt        <= '0;
`ifdef QSPI_CONTINUOUS_READ_EN
                                    state      <= S_HOLD;
                                    req_ready  <= 1'b1;
`else
                                    state      <= S_DONE;
                                    select_n   <= 1'b1;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end
`ifdef QSPI_CONTINUOUS_READ_EN
                S_HOLD: begin
                    // The flash keeps streaming from the last address, so only the next
                    // sequential byte can skip the command/address/dummy phases.
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        phase     <= 1'b0;
                        if (req_addr == addr_q + ADDR_ONE) begin
                            state <= S_DATA;
                        end else begin
                            state    <= S_DONE;
                            select_n <= 1'b1;
                            restart  <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
`ifdef QSPI_CONTINUOUS_READ_EN
                    if (restart) begin
                        restart  <= 1'b0;
                        state    <= S_CMD;
                        select_n <= 1'b0;
                        io_oe    <= 1'b1;
                        io_out   <= READ_CMD[7:4];
                        cnt      <= '0;
                        phase    <= 1'b0;
                    end else
`endif
                    begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    select_n  <= 1'b1;
                    sclk      <= 1'b0;
                    io_oe     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/qspi_rom_reader.md
QSPI_ROM_READER -- requirements
Module: qspi_rom_reader

Interface
REQ-001 SHALL have parameter DUMMY_NIBBLES, default 4, number of SCLK cycles between address and data.
REQ-002 SHALL have parameter READ_CMD, default 8'hEB, quad-I/O read opcode.
REQ-003 SHALL have parameter ADDR_BITS, default 24, transmitted address width (multiple of 4).
REQ-004 clk_pixel  input  1  sole clock; one clock and synchronous active-high reset (reset), as decided.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req_valid  input  1  read request.
REQ-007 req_addr  input  ADDR_BITS  byte address.
REQ-008 req_ready  output  1  request accepted when req_valid&req_ready.
REQ-009 resp_valid  output  1  one-cycle pulse, resp_data valid.
REQ-010 resp_data  output  8  fetched byte.
REQ-011 select_n  output  1  flash chip select, active-low.
REQ-012 sclk  output  1  flash serial clock.
REQ-013 io_out  output  4  nibble driven to flash, bit3 = MSB.
REQ-014 io_oe  output  1  high while io_out drives the bus.
REQ-015 io_in  input  4  nibble returned by flash.

Function
REQ-016 States: IDLE, CMD, ADDR, DUMMY, DATA, DONE (+HOLD, see REQ-030).
REQ-017 Each nibble occupies two clk_pixel cycles: phase 0 sclk=0 with io_out updated; phase 1 sclk=1.
REQ-018 io_in sampled on the clock edge ending phase 1 (sclk 1->0).
REQ-019 req_ready high only in IDLE (and HOLD when enabled); acceptance latches req_addr.
REQ-020 Cycle after acceptance: select_n=0, state CMD; READ_CMD sent as 2 nibbles MSB first, io_oe=1.
REQ-021 ADDR: ADDR_BITS/4 nibbles MSB first, io_oe=1.
REQ-022 DUMMY: DUMMY_NIBBLES sclk cycles, io_oe=0, io_out=0.
REQ-023 DATA: 2 nibbles, io_oe=0; first sampled nibble -> resp_data[7:4], second -> [3:0].
REQ-024 DONE: resp_valid=1 one cycle, select_n=1, sclk=0; next cycle IDLE.
REQ-025 Default latency acceptance->resp_valid = 2*(2+ADDR_BITS/4+DUMMY_NIBBLES+2)+1 = 29 clk_pixel cycles.
REQ-026 select_n high for at least one cycle between transactions (DONE cycle).
REQ-027 resp_data holds its value until the next resp_valid.
REQ-028 req_valid while not ready is ignored, not queued.

Reset
REQ-029 On reset, whatever state (mid-transaction included): state IDLE, select_n=1, sclk=0, io_oe=0, io_out=0, resp_valid=0, resp_data=0, req_ready=1 the following cycle; the aborted transaction yields no response.

Configuration
REQ-030 Macro QSPI_CONTINUOUS_READ_EN defined: after DATA the block enters HOLD instead of DONE, pulses resp_valid, keeps select_n=0, sclk=0; a request with addr == previous+1 goes straight to DATA (latency 5 cycles); any other address deasserts select_n one cycle then runs the full sequence.
REQ-031 Macro undefined: no HOLD state; every request performs the full sequence of REQ-020..024.

Structure
REQ-032 Package qspi_pkg holds the state enum, default READ_CMD constant and nibble-count constants, shared with the ROM emulator.
REQ-033 Single module; nibble shift/sample logic inline, no sub-module.

Verification
REQ-034 Reset, req addr 24'h000123 -> io_out nibbles E,B,0,0,0,1,2,3; 4 dummy cycles io_oe=0; resp_valid at cycle 29.
REQ-035 Emulator returns byte 8'hA5 -> resp_data=8'hA5, resp_valid exactly one cycle, select_n high same cycle.
REQ-036 reset asserted during ADDR -> next cycle select_n=1, sclk=0, no resp_valid ever for that request.
REQ-037 req_valid held continuously, addrs 0x10,0x11 without macro -> two full 29-cycle transactions, select_n high between.
REQ-038 With QSPI_CONTINUOUS_READ_EN: addrs 0x10,0x11,0x40 -> second response 5 cycles after acceptance, third preceded by one-cycle select_n high and full command.
